seq_multplr_n: RTL
==================

Name: seq_multplr_n

Overview:
- Parametrised N-bit sequential shift-add multiplier with its control and datapath in one block.
- Successor to the 4-bit sequential multiplier. Adds:
  - a generic operand width
  - run-time signed/unsigned mode
  - a start/busy/done handshake
  - add and shift in the same cycle (one multiplier bit per clock)
  - early termination once the remaining multiplier bits are zero
- Sits between switch/register operand sources and any consumer that latches the product on done.

Parameters:
- WIDTH, 8: operand width in bits, legal 2..32. The product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiplication; sampled only in IDLE.
- signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled at start acceptance.
- b  input  WIDTH  multiplier; sampled at start acceptance.
- busy  output  1  high from acceptance until the done cycle, inclusive of the done edge.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  result, held until the next completion.

Behaviour:
- Reset (clr_n low, asynchronous):
  - state = IDLE; busy = 0, done = 0, product = 0.
  - All internal registers are 0.
  - Asserting reset mid-operation aborts the operation; no done pulse follows.
- Internal registers:
  - A_reg, 2*WIDTH bits: shifted multiplicand.
  - B_reg, WIDTH bits: remaining multiplier.
  - P_reg, 2*WIDTH bits: accumulator.
  - neg, 1 bit: result sign.
- States: IDLE, CALC, FIX.
- IDLE:
  - done is cleared every cycle unless set by FIX on the previous edge.
  - On an edge with start = 1:
    - A_reg = zero-extended |a|, B_reg = |b|, P_reg = 0.
    - neg = signed_mode & (a[MSB] ^ b[MSB]).
    - busy = 1, done = 0; go to CALC.
  - Magnitudes are taken as two's-complement negation only when signed_mode = 1 and the operand MSB = 1. Otherwise the raw value is used.
  - The most negative value maps to magnitude 2^(WIDTH-1), which fits unsigned in WIDTH bits.
- CALC, per edge:
  - If B_reg == 0: go to FIX; registers unchanged.
  - Else, all in the same edge:
    - P_reg += (B_reg[0] ? A_reg : 0), modulo 2^(2*WIDTH).
    - A_reg <<= 1.
    - B_reg >>= 1 (logical shift).
- FIX, one edge:
  - product = neg ? -P_reg : P_reg (2*WIDTH-bit two's complement).
  - done = 1, busy = 0; go to IDLE.
- Latency:
  - Let k = index of the highest set bit of |b| + 1, with k = 0 when b == 0.
  - Acceptance is edge 0; CALC shifts on edges 1..k; edge k+1 moves to FIX; edge k+2 registers product and raises done.
  - done is high during the cycle after edge k+2.
  - Minimum latency is 2 cycles; maximum is WIDTH+2 cycles.
- Handshake and boundary conditions:
  - start while busy is ignored; no queueing.
  - start held high in the done cycle is accepted at the next edge, and done then drops.
  - Holding start continuously yields back-to-back operations.
  - a, b and signed_mode may change freely after acceptance without affecting the result.
  - product changes only on FIX edges and never shows intermediate values.
  - Unsigned results never overflow 2*WIDTH bits.
  - Signed extreme case (min × min) yields +2^(2*WIDTH-2), which is representable.

Test Plan:
- WIDTH=8, unsigned, a=0x0D, b=0x0B, one-cycle start → busy next cycle; done pulses exactly 6 cycles after acceptance (k=4); product=0x008F.
- WIDTH=8, unsigned, a=0xFF, b=0xFF → done at acceptance+10 cycles; product=0xFE01. Same operands with b=0x00 → done at acceptance+2; product=0x0000.
- WIDTH=8, signed: a=0x80 (-128), b=0x80 → product=0x4000. a=0x80, b=0x7F → product=0xC080 (-16256). a=0xFD (-3), b=0x05 → product=0xFFF1.
- start re-pulsed during busy, with a and b changed mid-operation → ignored; the original operands' result is produced. start held high across done → second operation accepted on the cycle after done; exactly one done pulse per operation.
- Drive clr_n low asynchronously mid-CALC (between edges) → busy, done and product are 0 immediately. After release, no done pulse until a new start; the next operation completes correctly.
- WIDTH=4 regression: all 256 unsigned pairs and all 256 signed pairs checked against a reference product. done latency equals k+2 for every pair.

Source files
------------

// File: rtl/seq_multplr_n.sv
// Parametrised sequential shift-add multiplier with signed/unsigned mode,
// start/busy/done handshake and early exit once the remaining multiplier is zero.
//
// state | meaning
// IDLE  | waiting for start; operands are latched on the accepting edge
// CALC  | one multiplier bit per edge: conditional add, shift A left, B right
// FIX   | apply result sign, register product, pulse done
module seq_multplr_n #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q;
    logic [2*WIDTH-1:0]   a_reg_q;
    logic [WIDTH-1:0]     b_reg_q;
    logic [2*WIDTH-1:0]   p_reg_q;
    logic                 neg_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     mag_a_d;
    logic [WIDTH-1:0]     mag_b_d;
    logic                 neg_d;
    logic [2*WIDTH-1:0]   addend_d;
    logic [2*WIDTH-1:0]   p_sum_d;
    logic [2*WIDTH-1:0]   fix_d;

    // The most negative operand negates to itself, which read unsigned is 2^(WIDTH-1).
    always_comb begin
        mag_a_d  = (signed_mode && a[WIDTH-1]) ? -a : a;
        mag_b_d  = (signed_mode && b[WIDTH-1]) ? -b : b;
        neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        addend_d = b_reg_q[0] ? a_reg_q : '0;
        p_sum_d  = p_reg_q + addend_d;
        fix_d    = neg_q ? -p_reg_q : p_reg_q;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            a_reg_q   <= '0;
            b_reg_q   <= '0;
            p_reg_q   <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_reg_q <= {{WIDTH{1'b0}}, mag_a_d};
                        b_reg_q <= mag_b_d;
                        p_reg_q <= '0;
                        neg_q   <= neg_d;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (b_reg_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        p_reg_q <= p_sum_d;
                        a_reg_q <= a_reg_q << 1;
                        b_reg_q <= b_reg_q >> 1;
                    end
                end
                FIX: begin
                    product_q <= fix_d;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
